// File: rtl/mux4_rr_arbiter.sv
// rtl/mux4_rr_arbiter.sv - four-requester round-robin arbiter driving a shared registered 4:1 mux
//
// Purpose:
//   Grants one of four requesters access to a shared 1-bit 4:1 mux.
//   Arbitration is round-robin: the search starts one past the most recent
//   grantee, so the most recent grantee has the lowest priority. A grantee
//   keeps the grant for at most MAX_HOLD consecutive cycles. Arbitration
//   happens only when a grant is released, so a new request never preempts
//   the current holder.
//
// Ports:
//   clk      in   1  clock; all state changes on the rising edge
//   rst      in   1  synchronous active-high reset
//   req      in   4  request vector; bit i is requester i
//   in0..in3 in   1  data of requesters 0..3
//   grant    out  4  registered one-hot grant; all zeros when idle
//   sel      out  2  registered index of the grantee; kept while idle
//   busy     out  1  registered; high while grant is non-zero
//   out      out  1  registered mux output, in[sel] from the previous cycle
//   out_vld  out  1  registered; busy delayed by one cycle, qualifies out

module mux4_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       in0,
  input  logic       in1,
  input  logic       in2,
  input  logic       in3,
  output logic [3:0] grant,
  output logic [1:0] sel,
  output logic       busy,
  output logic       out,
  output logic       out_vld
);

  localparam logic [3:0] MAX_HOLD_C = 4'(MAX_HOLD);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t     state, state_nxt;
  logic [1:0] last, last_nxt;
  logic [1:0] sel_nxt;
  logic [1:0] win;
  logic [3:0] hold, hold_nxt;
  logic [3:0] grant_nxt;
  logic       busy_nxt;
  logic       any_req;
  logic       release_now;
  logic [3:0] data_vec;

  assign any_req  = |req;
  assign data_vec = {in3, in2, in1, in0};

  // Round-robin winner. The loop runs from the farthest candidate (last
  // itself) to the nearest (last+1), so the nearest requesting index is
  // the one that sticks. The 2-bit index sum wraps modulo 4.
  always_comb begin
    win = last + 2'd1;
    for (int k = 3; k >= 0; k--) begin
      if (req[last + 2'(k + 1)]) begin
        win = last + 2'(k + 1);
      end
    end
  end

  // A grant ends when its owner drops the request or uses up its hold budget.
  assign release_now = !req[sel] || (hold == MAX_HOLD_C);

  // State register and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      last    <= 2'd3;
      hold    <= 4'd0;
      grant   <= 4'd0;
      sel     <= 2'd0;
      busy    <= 1'b0;
      out     <= 1'b0;
      out_vld <= 1'b0;
    end else begin
      state   <= state_nxt;
      last    <= last_nxt;
      hold    <= hold_nxt;
      grant   <= grant_nxt;
      sel     <= sel_nxt;
      busy    <= busy_nxt;
      // The datapath uses the pre-edge sel and busy, so out and out_vld
      // trail grant by exactly one cycle.
      out     <= data_vec[sel];
      out_vld <= busy;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    sel_nxt   = sel;
    hold_nxt  = hold;
    case (state)
      IDLE: begin
        if (any_req) begin
          state_nxt = GRANT;
          sel_nxt   = win;
          last_nxt  = win;
          hold_nxt  = 4'd1;
        end
      end
      GRANT: begin
        if (release_now) begin
          if (any_req) begin
            // If the holder is the only requester, the search wraps
            // around to it, so it is re-granted with a new hold budget.
            sel_nxt  = win;
            last_nxt = win;
            hold_nxt = 4'd1;
          end else begin
            state_nxt = IDLE;
            hold_nxt  = 4'd0;
          end
        end else begin
          hold_nxt = hold + 4'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Output logic: the next grant and busy follow from the next state.
  always_comb begin
    grant_nxt = 4'd0;
    busy_nxt  = 1'b0;
    if (state_nxt == GRANT) begin
      grant_nxt = 4'b0001 << sel_nxt;
      busy_nxt  = 1'b1;
    end
  end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// tb/tb_mux4_rr_arbiter.sv - scoreboard testbench for mux4_rr_arbiter

module tb_mux4_rr_arbiter;

  localparam int MAX_HOLD = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = 4'd0;
  logic       in0 = 1'b0;
  logic       in1 = 1'b0;
  logic       in2 = 1'b0;
  logic       in3 = 1'b0;
  logic [3:0] grant;
  logic [1:0] sel;
  logic       busy;
  logic       out;
  logic       out_vld;

  mux4_rr_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .in0     (in0),
    .in1     (in1),
    .in2     (in2),
    .in3     (in3),
    .grant   (grant),
    .sel     (sel),
    .busy    (busy),
    .out     (out),
    .out_vld (out_vld)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] grant;
    logic [1:0] sel;
    logic       busy;
    logic       out;
    logic       vld;
  } exp_t;

  exp_t sbq[$];

  int checks = 0;
  int errors = 0;

  // Bench's view of sel and busy before the next edge.
  logic [1:0] cur_sel  = 2'd0;
  logic       cur_busy = 1'b0;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, expv, $time);
    end
  endtask

  function automatic logic [3:0] rnd4();
    return 4'($urandom_range(0, 15));
  endfunction

  // One cycle of stimulus plus the hand-computed state expected after the edge.
  task automatic step(input logic r, input logic [3:0] q, input logic [3:0] d,
                      input logic [3:0] eg, input logic [1:0] es);
    exp_t e;
    @(negedge clk);
    rst = r;
    req = q;
    {in3, in2, in1, in0} = d;
    e.grant = eg;
    e.sel   = es;
    e.busy  = (eg != 4'd0);
    e.out   = r ? 1'b0 : d[cur_sel];
    e.vld   = r ? 1'b0 : cur_busy;
    sbq.push_back(e);
    cur_sel  = es;
    cur_busy = e.busy;
  endtask

  task automatic do_reset();
    step(1'b1, 4'd0, rnd4(), 4'd0, 2'd0);
  endtask

  task automatic step_rand();
    @(negedge clk);
    rst = 1'b0;
    req = rnd4();
    {in3, in2, in1, in0} = rnd4();
  endtask

  // Monitor: snapshot the pre-edge view late in the low phase, then check
  // the scoreboard and the invariants just after the rising edge.
  initial begin
    logic [3:0] p_req, p_d, p_grant;
    logic [1:0] p_sel;
    logic       p_rst;
    int         streak;
    exp_t       e;
    streak = 0;
    forever begin
      @(negedge clk);
      #4;
      p_rst   = rst;
      p_req   = req;
      p_d     = {in3, in2, in1, in0};
      p_grant = grant;
      p_sel   = sel;
      @(posedge clk);
      #1;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("grant", 8'(grant), 8'(e.grant));
        chk("sel", 8'(sel), 8'(e.sel));
        chk("busy", 8'(busy), 8'(e.busy));
        chk("out", 8'(out), 8'(e.out));
        chk("out_vld", 8'(out_vld), 8'(e.vld));
      end
      chk("onehot", 8'($countones(grant) <= 1), 8'd1);
      if (grant != 4'd0) chk("sel_match", 8'(grant), 8'(4'b0001 << sel));
      if (!p_rst && out_vld) chk("out_prior", 8'(out), 8'(p_d[p_sel]));
      if (!p_rst && grant != 4'd0 && grant == p_grant && (p_req & ~p_grant) != 4'd0)
        streak++;
      else
        streak = 0;
      chk("hold_len", 8'(streak < MAX_HOLD), 8'd1);
    end
  end

  initial begin
    logic tog;
    int   idx;

    // Reset state, then a sole requester re-granted every MAX_HOLD cycles.
    do_reset();
    do_reset();
    tog = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tog = ~tog;
      step(1'b0, 4'b0001, {3'($urandom_range(0, 7)), tog}, 4'b0001, 2'd0);
    end
    step(1'b0, 4'b0000, rnd4(), 4'b0000, 2'd0);

    // All four requesting: 4 cycles each, rotating 0,1,2,3,0.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      idx = (i / 4) % 4;
      step(1'b0, 4'hf, rnd4(), 4'b0001 << idx, 2'(idx));
    end

    // Early release by dropping the request, then idle with sel kept.
    do_reset();
    step(1'b0, 4'b0101, rnd4(), 4'b0001, 2'd0);
    step(1'b0, 4'b0101, rnd4(), 4'b0001, 2'd0);
    step(1'b0, 4'b0100, rnd4(), 4'b0100, 2'd2);
    step(1'b0, 4'b0000, rnd4(), 4'b0000, 2'd2);
    step(1'b0, 4'b0000, rnd4(), 4'b0000, 2'd2);

    // No preemption: 1 holds for 4 cycles, then 3 wins, then 0.
    do_reset();
    step(1'b0, 4'b0010, rnd4(), 4'b0010, 2'd1);
    for (int i = 0; i < 11; i++) begin
      if (i < 3)      step(1'b0, 4'b1011, rnd4(), 4'b0010, 2'd1);
      else if (i < 7) step(1'b0, 4'b1011, rnd4(), 4'b1000, 2'd3);
      else            step(1'b0, 4'b1011, rnd4(), 4'b0001, 2'd0);
    end

    // Reset while requester 2 holds the grant, then resume at requester 0.
    do_reset();
    for (int i = 0; i < 9; i++) begin
      idx = i / 4;
      step(1'b0, 4'hf, rnd4(), 4'b0001 << idx, 2'(idx));
    end
    step(1'b1, 4'hf, rnd4(), 4'b0000, 2'd0);
    step(1'b0, 4'hf, rnd4(), 4'b0001, 2'd0);

    // Random traffic, checked by the invariants only.
    do_reset();
    for (int i = 0; i < 1000; i++) step_rand();

    repeat (3) @(negedge clk);
    chk("sb_drain", 8'(sbq.size()), 8'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux4_rr_arbiter.md
MUX4_RR_ARBITER -- requirements
Module: mux4_rr_arbiter

Interface
REQ-001 Parameter: MAX_HOLD, default 4, maximum consecutive grant cycles per requester (legal 1..15).
REQ-002 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  synchronous, active-high reset.
REQ-004 Port: req  input  4  request vector; bit i = requester i wants the shared mux.
REQ-005 Port: in0  input  1  data of requester 0.
REQ-006 Port: in1  input  1  data of requester 1.
REQ-007 Port: in2  input  1  data of requester 2.
REQ-008 Port: in3  input  1  data of requester 3.
REQ-009 Port: grant  output  4  registered one-hot grant; all-zero when idle.
REQ-010 Port: sel  output  2  registered index of current grantee; drives the shared 4:1 mux.
REQ-011 Port: busy  output  1  registered; 1 when grant is non-zero.
REQ-012 Port: out  output  1  registered selected data.
REQ-013 Port: out_vld  output  1  registered; qualifies out.

Function
REQ-014 Two states SHALL exist: IDLE (grant=0) and GRANT (grant one-hot).
REQ-015 A 2-bit pointer last SHALL hold the most recently granted index; priority search SHALL start at last+1 and wrap modulo 4 (last itself lowest priority).
REQ-016 IDLE, req==0 at edge: SHALL stay IDLE, outputs unchanged.
REQ-017 IDLE, req!=0 at edge: SHALL enter GRANT with winner w per REQ-015; grant=1<<w, sel=w, last=w, hold count=1; latency one cycle from req sample to grant.
REQ-018 GRANT, at each edge: release SHALL occur if req[sel]==0 or hold count==MAX_HOLD; otherwise hold count increments, grant/sel unchanged.
REQ-019 On release with req!=0 (current requester included): SHALL switch directly to new winner per REQ-015, hold count=1, no idle gap.
REQ-020 On release with req==0: SHALL go to IDLE; grant=0, busy=0; sel SHALL retain last value.
REQ-021 Sole requester reaching MAX_HOLD SHALL be re-granted immediately (hold count restarts at 1, grant unchanged).
REQ-022 Requests arriving mid-grant SHALL NOT preempt; they are considered only at release.
REQ-023 grant SHALL never have more than one bit set; sel SHALL equal the index of the set bit whenever grant!=0.
REQ-024 Datapath: every edge, out SHALL load in[sel] (values of in0..in3 and sel before the edge) and out_vld SHALL load busy; out/out_vld lag grant by exactly one cycle.
REQ-025 Hold counter SHALL be 4 bits, never exceed MAX_HOLD, never wrap.

Reset
REQ-026 rst=1 at an edge SHALL force: state IDLE, grant=0, sel=0, busy=0, out=0, out_vld=0, hold count=0, last=3 (requester 0 highest priority next).
REQ-027 Reset SHALL take priority over all other events, including mid-grant; req sampled in the reset cycle SHALL be ignored.
REQ-028 First edge after rst deasserts SHALL evaluate req per REQ-017.

Verification (MAX_HOLD=4)
REQ-029 Reset, then req=0001 held 12 cycles, in0 toggling each cycle -> grant=0001, sel=0 from one cycle after req, continuous (re-grants every 4 cycles); out equals previous-cycle in0, out_vld=1 from second grant cycle.
REQ-030 Reset, req=1111 held -> grant 0001,0010,0100,1000,0001 each for exactly 4 cycles, no idle cycles, busy stays 1.
REQ-031 Reset, req=0101; drop req[0] after its 2nd grant cycle -> grant=0001 for 2 cycles then 0100 next edge; drop all req -> grant=0000, busy=0, out_vld=0 one cycle later.
REQ-032 While grant=0010 (count 1), raise req[0]=1 and req[3]=1 -> no preemption for 4 cycles; next grant=1000 (search from 2), then 0001.
REQ-033 rst=1 while grant=0100 with req=1111 -> next edge grant=0, sel=0, out=0, out_vld=0; release rst with req=1111 -> grant=0001.
REQ-034 Random req/in0..in3 for 1000 cycles -> checker: grant one-hot or zero, sel matches grant, no grant longer than 4 cycles while another req pending, out == prior in[sel] when out_vld.
